moldudp64_header_parser: RTL and testbench

- Receives raw UDP payload beats from the UDP receive stage.
- Strips and decodes the 20-byte MoldUDP64 header: session (10 B), sequence number (8 B), message count (2 B).
- Forwards the message-block stream, starting with the beat that carries the first 2-byte message length, to the message dispatcher.
- Performs session/sequence tracking and flags gaps, duplicates, heartbeats, end-of-session and truncated packets.

---
 rtl/moldudp64_header_parser.sv | 219 +++++++++++++++++++++
 tb/tb_moldudp64_header_parser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_header_parser.sv
// MoldUDP64 header parser: strips the 20-byte header, decodes session/sequence/count and forwards the message block.
// Define MOLD_SEQ_CHECK_EN to enable sequence tracking (gap and duplicate detection).
module moldudp64_header_parser #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SID_W      = 80,
    parameter int SEQ_W      = 64,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  valid_i,
    input  logic [AXI_DATA_W-1:0] data_i,
    input  logic [AXI_KEEP_W-1:0] keep_i,
    input  logic                  last_i,
    output logic                  valid_o,
    output logic [AXI_DATA_W-1:0] data_o,
    output logic [AXI_KEEP_W-1:0] keep_o,
    output logic                  init_v_o,
    output logic                  last_o,
    output logic                  hdr_v_o,
    output logic [SID_W-1:0]      sid_o,
    output logic [SEQ_W-1:0]      seq_o,
    output logic [CNT_W-1:0]      msg_cnt_o,
    output logic                  heartbeat_o,
    output logic                  eos_o,
    output logic                  trunc_o,
    output logic                  gap_v_o,
    output logic [SEQ_W-1:0]      gap_seq_o,
    output logic [SEQ_W-1:0]      gap_cnt_o,
    output logic                  dup_o
);

    typedef enum logic [2:0] {H0, H1, H2, FWD, DROP} state_t;

    localparam logic [AXI_KEEP_W-1:0] HDR_KEEP = AXI_KEEP_W'(15);

    // Byte 0 of the beat is the first byte on the wire, i.e. the most significant of a big-endian field.
    function automatic logic [63:0] to_be64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = d[8*i +: 8];
        return r;
    endfunction

    state_t        state_q;
    logic [63:0]   sid_hi_q;
    logic [15:0]   sid_lo_q;
    logic [47:0]   seq_hi_q;
    logic [63:0]   beat_be;
    logic [SID_W-1:0] new_sid;
    logic [SEQ_W-1:0] new_seq;
    logic [CNT_W-1:0] new_cnt;
    logic          hb;
    logic          eos;
    logic          hdr_done;
    logic          accept;

    assign beat_be  = to_be64(data_i);
    assign new_sid  = {sid_hi_q, sid_lo_q};
    assign new_seq  = {seq_hi_q, beat_be[63:48]};
    assign new_cnt  = beat_be[47:32];
    assign hb       = (new_cnt == '0);
    assign eos      = (new_cnt == '1);
    assign hdr_done = valid_i && (state_q == H2) && !(last_i && (keep_i < HDR_KEEP));

    // Header capture registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            case (state_q)
                H0: sid_hi_q <= beat_be;
                H1: begin
                    sid_lo_q <= beat_be[63:48];
                    seq_hi_q <= beat_be[47:0];
                end
                default: ;
            endcase
        end
    end

`ifdef MOLD_SEQ_CHECK_EN
    logic [SEQ_W-1:0] exp_seq_q;
    logic [SEQ_W-1:0] exp_seq_d;
    logic             sync_q;
    logic             sync_d;
    logic             tracked;
    logic             gap;
    logic             dup;

    always_comb begin
        accept    = 1'b1;
        gap       = 1'b0;
        dup       = 1'b0;
        exp_seq_d = exp_seq_q;
        sync_d    = sync_q;
        tracked   = sync_q && (new_sid == sid_o);
        if (hb) begin
            if (tracked && (new_seq > exp_seq_q)) begin
                gap       = 1'b1;
                exp_seq_d = new_seq;
            end
        end else if (!eos) begin
            if (!tracked) begin
                exp_seq_d = new_seq + SEQ_W'(new_cnt);
                sync_d    = 1'b1;
            end else if (new_seq < exp_seq_q) begin
                accept = 1'b0;
                dup    = 1'b1;
            end else begin
                gap       = (new_seq > exp_seq_q);
                exp_seq_d = new_seq + SEQ_W'(new_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            exp_seq_q <= '0;
            sync_q    <= 1'b0;
            gap_v_o   <= 1'b0;
            gap_seq_o <= '0;
            gap_cnt_o <= '0;
            dup_o     <= 1'b0;
        end else begin
            gap_v_o <= 1'b0;
            dup_o   <= 1'b0;
            if (hdr_done) begin
                exp_seq_q <= exp_seq_d;
                sync_q    <= sync_d;
                gap_v_o   <= gap;
                dup_o     <= dup;
                if (gap) begin
                    gap_seq_o <= exp_seq_q;
                    gap_cnt_o <= new_seq - exp_seq_q;
                end
            end
        end
    end
`else
    assign accept    = 1'b1;
    assign gap_v_o   = 1'b0;
    assign gap_seq_o = '0;
    assign gap_cnt_o = '0;
    assign dup_o     = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= H0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            keep_o      <= '0;
            init_v_o    <= 1'b0;
            last_o      <= 1'b0;
            hdr_v_o     <= 1'b0;
            sid_o       <= '0;
            seq_o       <= '0;
            msg_cnt_o   <= '0;
            heartbeat_o <= 1'b0;
            eos_o       <= 1'b0;
            trunc_o     <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            init_v_o    <= 1'b0;
            last_o      <= 1'b0;
            hdr_v_o     <= 1'b0;
            heartbeat_o <= 1'b0;
            eos_o       <= 1'b0;
            trunc_o     <= 1'b0;
            if (valid_i) begin
                case (state_q)
                    H0: begin
                        if (last_i) trunc_o <= 1'b1;
                        else        state_q <= H1;
                    end
                    H1: begin
                        trunc_o <= last_i;
                        state_q <= last_i ? H0 : H2;
                    end
                    H2: begin
                        if (!hdr_done) begin
                            trunc_o <= 1'b1;
                            state_q <= H0;
                        end else begin
                            hdr_v_o     <= 1'b1;
                            sid_o       <= new_sid;
                            seq_o       <= new_seq;
                            msg_cnt_o   <= new_cnt;
                            heartbeat_o <= hb;
                            eos_o       <= eos;
                            // The message block begins at byte 4 of this beat.
                            if (!hb && !eos && accept) begin
                                valid_o  <= 1'b1;
                                init_v_o <= 1'b1;
                                last_o   <= last_i;
                                data_o   <= data_i;
                                keep_o   <= keep_i;
                                state_q  <= last_i ? H0 : FWD;
                            end else begin
                                state_q  <= last_i ? H0 : DROP;
                            end
                        end
                    end
                    FWD: begin
                        valid_o <= 1'b1;
                        last_o  <= last_i;
                        data_o  <= data_i;
                        keep_o  <= keep_i;
                        if (last_i) state_q <= H0;
                    end
                    DROP: begin
                        if (last_i) state_q <= H0;
                    end
                    default: state_q <= H0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moldudp64_header_parser.sv
// Randomized self-checking bench for moldudp64_header_parser with a packet-level reference model.
module tb_moldudp64_header_parser;

    logic         clk = 1'b0;
    logic         nreset;
    logic         valid_i;
    logic [63:0]  data_i;
    logic [7:0]   keep_i;
    logic         last_i;
    logic         valid_o;
    logic [63:0]  data_o;
    logic [7:0]   keep_o;
    logic         init_v_o;
    logic         last_o;
    logic         hdr_v_o;
    logic [79:0]  sid_o;
    logic [63:0]  seq_o;
    logic [15:0]  msg_cnt_o;
    logic         heartbeat_o;
    logic         eos_o;
    logic         trunc_o;
    logic         gap_v_o;
    logic [63:0]  gap_seq_o;
    logic [63:0]  gap_cnt_o;
    logic         dup_o;

    moldudp64_header_parser dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(data_i), .keep_i(keep_i),
        .last_i(last_i), .valid_o(valid_o), .data_o(data_o), .keep_o(keep_o),
        .init_v_o(init_v_o), .last_o(last_o), .hdr_v_o(hdr_v_o), .sid_o(sid_o),
        .seq_o(seq_o), .msg_cnt_o(msg_cnt_o), .heartbeat_o(heartbeat_o), .eos_o(eos_o),
        .trunc_o(trunc_o), .gap_v_o(gap_v_o), .gap_seq_o(gap_seq_o), .gap_cnt_o(gap_cnt_o),
        .dup_o(dup_o)
    );

    always #5 clk = ~clk;

    // Monitor: accumulates observed events; the driver only reads these.
    int          n_hdr, n_trunc, n_hb, n_eos, n_gap, n_dup;
    logic [63:0] g_seq, g_cnt;
    logic [63:0] fq_data[$];
    logic [7:0]  fq_keep[$];
    logic        fq_init[$];
    logic        fq_last[$];

    always @(negedge clk) begin
        if (hdr_v_o)     n_hdr++;
        if (trunc_o)     n_trunc++;
        if (heartbeat_o) n_hb++;
        if (eos_o)       n_eos++;
        if (dup_o)       n_dup++;
        if (gap_v_o) begin
            n_gap++;
            g_seq = gap_seq_o;
            g_cnt = gap_cnt_o;
        end
        if (valid_o) begin
            fq_data.push_back(data_o);
            fq_keep.push_back(keep_o);
            fq_init.push_back(init_v_o);
            fq_last.push_back(last_o);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: what a MoldUDP64 receiver should remember between packets.
    logic [63:0] m_exp;
    logic        m_sync;
    logic [79:0] m_sid;
    logic [63:0] m_seq;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_exp = '0; m_sync = 1'b0; m_sid = '0; m_seq = '0; m_cnt = '0;
    endtask

    function automatic logic [63:0] beat_data(input byte unsigned b[$], input int i);
        logic [63:0] d = '0;
        for (int j = 0; j < 8; j++) if (8*i + j < b.size()) d[8*j +: 8] = b[8*i + j];
        return d;
    endfunction

    function automatic logic [7:0] beat_keep(input byte unsigned b[$], input int i);
        logic [7:0] k = '0;
        for (int j = 0; j < 8; j++) if (8*i + j < b.size()) k[j] = 1'b1;
        return k;
    endfunction

    task automatic make_pkt(output byte unsigned b[$], input logic [79:0] sid,
                            input logic [63:0] seq, input logic [15:0] cnt, input int paylen);
        b = {};
        for (int i = 0; i < 10; i++) b.push_back(sid[79-8*i -: 8]);
        for (int i = 0; i < 8; i++)  b.push_back(seq[63-8*i -: 8]);
        b.push_back(cnt[15:8]);
        b.push_back(cnt[7:0]);
        for (int i = 0; i < paylen; i++) b.push_back(8'($urandom));
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic send(input byte unsigned b[$], input int bub);
        int nb = (b.size() + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            if (bub >= 100) idle();
            else for (int r = 0; r < 4 && $urandom_range(99) < bub; r++) idle();
            valid_i = 1'b1;
            data_i  = beat_data(b, i);
            keep_i  = beat_keep(b, i);
            last_i  = (i == nb - 1);
            idle();
            valid_i = 1'b0;
            last_i  = 1'b0;
        end
    endtask

    task automatic run_pkt(input byte unsigned b[$], input int bub);
        int h0 = n_hdr, t0 = n_trunc, hb0 = n_hb, e0 = n_eos, g0 = n_gap, d0 = n_dup;
        int f0 = fq_data.size();
        int L  = b.size();
        int nb = (L + 7) / 8;
        logic [79:0] sid; logic [63:0] seq; logic [15:0] cnt;
        logic hb = 0, eos = 0, acc = 1, gp = 0, dp = 0, trk;
        logic [63:0] gs = '0, gc = '0;
        int ef = 0, nf;
        send(b, bub);
        repeat (3) idle();
        if (L >= 20) begin
            for (int i = 0; i < 10; i++) sid[79-8*i -: 8] = b[i];
            for (int i = 0; i < 8; i++)  seq[63-8*i -: 8] = b[10+i];
            cnt = {b[18], b[19]};
            hb  = (cnt == 16'h0000);
            eos = (cnt == 16'hFFFF);
`ifdef MOLD_SEQ_CHECK_EN
            trk = m_sync && (sid == m_sid);
            if (hb) begin
                if (trk && seq > m_exp) begin gp = 1; gs = m_exp; gc = seq - m_exp; m_exp = seq; end
            end else if (!eos) begin
                if (!trk) begin m_exp = seq + 64'(cnt); m_sync = 1; end
                else if (seq < m_exp) begin acc = 0; dp = 1; end
                else begin
                    if (seq > m_exp) begin gp = 1; gs = m_exp; gc = seq - m_exp; end
                    m_exp = seq + 64'(cnt);
                end
            end
`else
            trk = 1'b0;
`endif
            m_sid = sid; m_seq = seq; m_cnt = cnt;
            if (!hb && !eos && acc) ef = nb - 2;
        end
        check("hdr",   n_hdr - h0,   (L >= 20) ? 1 : 0);
        check("trunc", n_trunc - t0, (L < 20) ? 1 : 0);
        check("hbeat", n_hb - hb0,   hb);
        check("eos",   n_eos - e0,   eos);
        check("gap",   n_gap - g0,   gp);
        check("dup",   n_dup - d0,   dp);
        if (gp) begin
            check("gap_seq", g_seq, gs);
            check("gap_cnt", g_cnt, gc);
        end
        nf = fq_data.size() - f0;
        check("nfwd", nf, ef);
        for (int k = 0; k < nf && k < ef; k++) begin
            check("fdata", fq_data[f0+k], beat_data(b, k + 2));
            check("fkeep", fq_keep[f0+k], beat_keep(b, k + 2));
            check("finit", fq_init[f0+k], k == 0);
            check("flast", fq_last[f0+k], k == ef - 1);
        end
        check("sid_held", sid_o, m_sid);
        check("seq_held", seq_o, m_seq);
        check("cnt_held", msg_cnt_o, m_cnt);
    endtask

    localparam logic [79:0] S0 = "SESSION001";
    localparam logic [79:0] S1 = "SESSION002";

    initial begin
        byte unsigned b[$];
        int f0, g0;
        logic [63:0] seq;
        logic [15:0] cnt;
        nreset = 1'b0; valid_i = 1'b0; data_i = '0; keep_i = '0; last_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_sid", sid_o, 0);
        check("rst_seq", seq_o, 0);
        check("rst_flags", {hdr_v_o, trunc_o, gap_v_o, dup_o, heartbeat_o, eos_o}, 0);
        nreset = 1'b1;
        idle();

        // Basic packet: 5 beats, 3 forwarded, first message length 0x0010.
        make_pkt(b, S0, 64'd1, 16'd2, 18);
        b[20] = 8'h00; b[21] = 8'h10;
        f0 = fq_data.size();
        run_pkt(b, 0);
        check("seq_dir", seq_o, 1);
        check("cnt_dir", msg_cnt_o, 2);
        check("nfwd_dir", fq_data.size() - f0, 3);
        if (fq_data.size() - f0 == 3) begin
            check("len_dir", {fq_data[f0][39:32], fq_data[f0][47:40]}, 16'h0010);
            check("lastkeep_dir", fq_keep[f0+2], 8'h3F);
        end

        // Heartbeat then end-of-session, neither forwards anything.
        make_pkt(b, S0, 64'd3, 16'h0000, 0);  run_pkt(b, 0);
        make_pkt(b, S0, 64'd3, 16'hFFFF, 12); run_pkt(b, 0);

        // Gap then duplicate.
        g0 = n_gap;
        make_pkt(b, S0, 64'd7, 16'd1, 6); run_pkt(b, 0);
`ifdef MOLD_SEQ_CHECK_EN
        check("gap_dir", n_gap - g0, 1);
        check("gap_seq_dir", g_seq, 3);
        check("gap_cnt_dir", g_cnt, 4);
`endif
        make_pkt(b, S0, 64'd5, 16'd1, 6); run_pkt(b, 0);

        // Truncation followed by a normal packet.
        make_pkt(b, S0, 64'd8, 16'd1, 0);
        b = b[0:7];
        run_pkt(b, 0);
        make_pkt(b, S0, 64'd8, 16'd1, 10); run_pkt(b, 0);

        // Bubble between every beat.
        make_pkt(b, S0, 64'd9, 16'd3, 20); run_pkt(b, 100);

        // Reset after the first beat of a packet.
        make_pkt(b, S1, 64'd40, 16'd2, 8);
        valid_i = 1'b1; data_i = beat_data(b, 0); keep_i = 8'hFF; last_i = 1'b0;
        idle();
        valid_i = 1'b0;
        nreset = 1'b0;
        model_reset();
        idle();
        check("mrst_sid", sid_o, 0);
        check("mrst_valid", valid_o, 0);
        nreset = 1'b1;
        idle();
        run_pkt(b, 0);

        // Sequence wrap.
        make_pkt(b, S1, 64'hFFFF_FFFF_FFFF_FFFD, 16'd2, 4); run_pkt(b, 0);
        make_pkt(b, S1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 4); run_pkt(b, 0);
        g0 = n_gap;
        make_pkt(b, S1, 64'd1, 16'd1, 4); run_pkt(b, 0);
        check("wrap_nogap", n_gap - g0, 0);

        // Randomized traffic.
        for (int p = 0; p < 200; p++) begin
            case ($urandom_range(3))
                0, 1:    seq = m_exp;
                2:       seq = m_exp + 64'($urandom_range(1, 10));
                default: seq = m_exp - 64'($urandom_range(1, 3));
            endcase
            case ($urandom_range(19))
                0, 1:    cnt = 16'h0000;
                2:       cnt = 16'hFFFF;
                default: cnt = 16'($urandom_range(1, 4));
            endcase
            make_pkt(b, ($urandom_range(9) == 0) ? S1 : S0, seq, cnt, $urandom_range(0, 40));
            if ($urandom_range(11) == 0) b = b[0:$urandom_range(0, 18)];
            run_pkt(b, $urandom_range(0, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
